// File: rtl/rr_arbiter4_pkg.sv
// Shared constants, state encoding and the round-robin scan for rr_arbiter4.
//   N_REQ    : number of requesters sharing the resource
//   state_t  : arbiter state (ST_IDLE = no grant, ST_BUSY = grant active)
//   rr_pick  : first set request bit scanning from ptr upwards, modulo N_REQ
package rr_arbiter4_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Rotating-priority pick: ptr has highest priority, then ptr+1, ... with
  // wrap-around. When req is zero the result is don't-care (ptr is returned).
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder2to4.sv
// 2-to-4 one-hot decoder.
//   A : binary index in
//   Y : one-hot out, Y[i] = (A == i)
module decoder2to4 (
  input  logic [1:0] A,
  output logic [3:0] Y
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      assign Y[gi] = (A == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a bounded hold time.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   en        : allows new grants (does not affect a grant in progress)
//   req       : level requests, one per requester
//   gnt       : one-hot grant, zero whenever no grant is active
//   gnt_idx   : index of the current / most recent grantee
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse in the first idle cycle after a forced release
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       ptr_reg;
  logic [1:0]       gnt_idx_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             timeout_reg;

  logic             own_req;
  logic             hold_expired;
  logic             start_grant;
  logic             release_now;
  logic [1:0]       pick;
  logic [N_REQ-1:0] dec_y;

  assign own_req      = req[gnt_idx_reg];
  assign hold_expired = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
  assign start_grant  = (state_reg == ST_IDLE) && en && (|req);
  assign release_now  = (state_reg == ST_BUSY) && (!own_req || hold_expired);
  assign pick         = rr_pick(req, ptr_reg);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_grant) state_next = ST_BUSY;
      ST_BUSY: if (release_now) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant bookkeeping: pointer, grantee index, hold counter, timeout pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg      <= 2'd0;
      gnt_idx_reg  <= 2'd0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      // A release with the owner still requesting can only be an expiry;
      // an owner that dropped its request takes precedence as voluntary.
      timeout_reg <= release_now && own_req;
      if (start_grant) begin
        gnt_idx_reg  <= pick;
        hold_cnt_reg <= '0;
      end else if (state_reg == ST_BUSY) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
      if (release_now) begin
        ptr_reg <= gnt_idx_reg + 2'd1;
      end
    end
  end

  decoder2to4 u_dec (
    .A (gnt_idx_reg),
    .Y (dec_y)
  );

  // Outputs
  always_comb begin
    gnt_valid = (state_reg == ST_BUSY);
    gnt       = dec_y & {N_REQ{gnt_valid}};
    gnt_idx   = gnt_idx_reg;
    timeout   = timeout_reg;
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, for how many cycles so far,
  // and where the next round-robin scan begins.
  bit m_busy    = 0;
  int m_owner   = 0;
  int m_len     = 0;
  int m_next    = 0;
  bit m_timeout = 0;
  int grant_log[$];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_len = 0; m_next = 0; m_timeout = 0;
    end else if (!m_busy) begin
      m_timeout = 0;
      if (en && req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req[(m_next + k) % 4]) begin
            m_owner = (m_next + k) % 4;
            break;
          end
        end
        m_busy = 1;
        m_len  = 1;
        grant_log.push_back(m_owner);
        $display("t=%0t grant -> requester %0d (req=%b)", $time, m_owner, req);
      end
    end else begin
      if (!req[m_owner] || m_len == MAX_HOLD) begin
        m_timeout = req[m_owner];
        m_busy    = 0;
        m_next    = (m_owner + 1) % 4;
      end else begin
        m_len++;
      end
    end
  endtask

  // One clock: advance the model on the edge, compare #1 later.
  task automatic tick();
    logic [3:0] exp_gnt;
    @(posedge clk);
    model_edge();
    #1;
    exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt",       gnt,                    exp_gnt);
    chk("gnt_idx",   {2'b00, gnt_idx},       4'(m_owner));
    chk("gnt_valid", {3'b000, gnt_valid},    {3'b000, m_busy});
    chk("timeout",   {3'b000, timeout},      {3'b000, m_timeout});
    chk("onehot0",   {3'b000, $onehot0(gnt)}, 4'b0001);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int run_len;

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 4'b0000;
    ticks(2);
    chk("reset_gnt", gnt, 4'b0000);
    rst_n = 1'b1;
    tick();

    // 1. single requester, then scan resumes at ptr=3
    en = 1'b1; req = 4'b0100;
    tick();
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_idx", {2'b00, gnt_idx}, 4'd2);
    ticks(2);
    req = 4'b0000;
    tick();
    chk("t1_drop", gnt, 4'b0000);
    req = 4'b1001;
    tick();
    chk("t1_ptr3", {2'b00, gnt_idx}, 4'd3);
    req = 4'b0000;
    ticks(2);

    // 2. all requesting, each owner releases after 2 grant cycles
    grant_log.delete();
    req = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      tick();
      req = (m_busy && m_len == 2) ? (4'b1111 & ~(4'b0001 << m_owner)) : 4'b1111;
    end
    chk("t2_count", 4'(grant_log.size()), 4'd5);
    if (grant_log.size() == 5) begin
      chk("t2_order0", 4'(grant_log[0]), 4'd0);
      chk("t2_order1", 4'(grant_log[1]), 4'd1);
      chk("t2_order2", 4'(grant_log[2]), 4'd2);
      chk("t2_order3", 4'(grant_log[3]), 4'd3);
      chk("t2_order4", 4'(grant_log[4]), 4'd0);
    end
    req = 4'b0000;
    ticks(3);

    // 3. hold expiry
    req = 4'b0010;
    tick();
    run_len = 0;
    while (gnt == 4'b0010 && run_len < 20) begin
      run_len++;
      tick();
    end
    chk("t3_len", 4'(run_len), 4'(MAX_HOLD));
    chk("t3_gap", gnt, 4'b0000);
    chk("t3_timeout", {3'b000, timeout}, 4'b0001);
    tick();
    chk("t3_regrant", gnt, 4'b0010);
    req = 4'b0000;
    ticks(2);

    // 4. voluntary release on the expiry cycle
    req = 4'b0010;
    tick();
    ticks(MAX_HOLD - 1);
    req = 4'b0000;
    tick();
    chk("t4_gnt", gnt, 4'b0000);
    chk("t4_timeout", {3'b000, timeout}, 4'b0000);
    ticks(2);

    // 5. enable gating
    en = 1'b0; req = 4'b1000;
    ticks(3);
    chk("t5_blocked", gnt, 4'b0000);
    en = 1'b1;
    tick();
    chk("t5_grant", gnt, 4'b1000);
    en = 1'b0;
    ticks(2);
    chk("t5_hold", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    req = 4'b1000;
    ticks(2);
    chk("t5_noregrant", gnt, 4'b0000);
    en = 1'b1;
    tick();
    chk("t5_reenable", gnt, 4'b1000);
    req = 4'b0000;
    ticks(2);

    // 6. reset mid-grant
    req = 4'b0001;
    tick();
    chk("t6_pre", gnt, 4'b0001);
    rst_n = 1'b0;
    tick();
    chk("t6_gnt", gnt, 4'b0000);
    chk("t6_idx", {2'b00, gnt_idx}, 4'd0);
    rst_n = 1'b1; req = 4'b1010;
    tick();
    chk("t6_first", {2'b00, gnt_idx}, 4'd1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 79) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
